seq_mul_core: RTL

SEQ_MUL_CORE -- requirements
Module: seq_mul_core

---
 rtl/seq_mul_pkg.sv | 13 +
 rtl/seq_mul_addsub.sv | 20 ++
 rtl/seq_mul_core.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared FSM state encoding and WIDTH legal range for seq_mul_core
package seq_mul_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_addsub.sv
// rtl/seq_mul_addsub.sv - (WIDTH+1)-bit add/subtract stage of the shift-add multiplier
// SEQ_MUL_SIGNED_EN: when undefined only the adder is built and sub is ignored.
module seq_mul_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

`ifdef SEQ_MUL_SIGNED_EN
  assign sum = sub ? (x - y) : (x + y);
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sum        = x + y;
`endif

endmodule

// File: rtl/seq_mul_core.sv
// rtl/seq_mul_core.sv - radix-2 sequential shift-add multiplier, one multiplier bit per enabled cycle
// SEQ_MUL_SIGNED_EN: defined -> signed_mode honoured; undefined -> unsigned datapath only.
module seq_mul_core
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_mul_core: WIDTH out of range");
  end

  state_t            state, state_n;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH:0]    acc;
  logic              sgn;
  logic              accept;
  logic              last;
  logic [WIDTH:0]    addend;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    acc_n;
  logic [WIDTH-1:0]  mplier_n;

  assign accept = ena && start && (state != RUN);
  assign last   = (count == '0);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // The multiplier MSB carries negative weight in two's complement, so its partial product is subtracted.
  assign addend = mplier[0] ? {sgn & mcand[WIDTH-1], mcand} : '0;

  seq_mul_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x   (acc),
    .y   (addend),
    .sub (sgn & last),
    .sum (sum)
  );

  assign acc_n    = {sgn & sum[WIDTH], sum[WIDTH:1]};
  assign mplier_n = {sum[0], mplier[WIDTH-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= 1'b0;
    end else if (accept) begin
      sgn <= signed_mode;
    end
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign sgn                = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (ena) begin
      case (state)
        IDLE:    if (start) state_n = RUN;
        RUN:     if (last) state_n = DONE;
        DONE:    state_n = start ? RUN : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else if (ena) begin
      if (accept) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        count  <= CW'(WIDTH - 1);
      end else if (state == RUN) begin
        acc    <= acc_n;
        mplier <= mplier_n;
        if (last) begin
          product <= {acc_n[WIDTH-1:0], mplier_n};
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule
